// File: rtl/vx_mem_port_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package vx_mem_port_arb_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Index width for storage; a single requester still needs one bit to hold "0".
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_port_arb_if.sv
// Line-sized cache memory bus: request channel towards memory, response channel back.
interface vx_mem_port_arb_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_SIZE  = 64,
    parameter int TAG_WIDTH  = 8
);
    logic                   req_valid;
    logic                   req_rw;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_SIZE*8-1:0] req_data;
    logic [DATA_SIZE-1:0]   req_byteen;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   req_ready;

    logic                   rsp_valid;
    logic [DATA_SIZE*8-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic                   rsp_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/vx_mem_port_arb_rsp.sv
// One-entry response register: strips the source index from the memory tag and
// presents the response only to the requester that issued it.
module vx_mem_port_arb_rsp
    import vx_mem_port_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    parameter  int DATA_W     = 512,
    parameter  int TAG_WIDTH  = 8,
    localparam int IDX_W      = $clog2(NUM_INPUTS),
    localparam int IDX_WI     = idx_bits(NUM_INPUTS),
    localparam int OTAG_W     = TAG_WIDTH + IDX_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  out_rsp_valid_i,
    input  logic [DATA_W-1:0]     out_rsp_data_i,
    input  logic [OTAG_W-1:0]     out_rsp_tag_i,
    output logic                  out_rsp_ready_o,
    output logic [NUM_INPUTS-1:0] in_rsp_valid_o,
    output logic [DATA_W-1:0]     in_rsp_data_o,
    output logic [TAG_WIDTH-1:0]  in_rsp_tag_o,
    input  logic [NUM_INPUTS-1:0] in_rsp_ready_i,
    output logic [NUM_INPUTS-1:0] rsp_fire_o
);
    logic                 valid_q, valid_d;
    logic [IDX_WI-1:0]    dest_q, dest_d, rsp_dest;
    logic [TAG_WIDTH-1:0] tag_q, tag_d, rsp_tag;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 accept, deliver, legal;

    if (IDX_W > 0) begin : g_idx
        assign rsp_dest = out_rsp_tag_i[IDX_W-1:0];
        assign rsp_tag  = out_rsp_tag_i[OTAG_W-1:IDX_W];
    end else begin : g_noidx
        assign rsp_dest = '0;
        assign rsp_tag  = out_rsp_tag_i;
    end

    assign legal           = 32'(rsp_dest) < NUM_INPUTS;
    assign deliver         = valid_q && in_rsp_ready_i[dest_q];
    assign out_rsp_ready_o = !valid_q || in_rsp_ready_i[dest_q];
    assign accept          = out_rsp_valid_i && out_rsp_ready_o;

    // An illegal index is still consumed from memory so the port cannot wedge.
    always_comb begin
        valid_d = valid_q && !deliver;
        dest_d  = dest_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (accept && legal) begin
            valid_d = 1'b1;
            dest_d  = rsp_dest;
            tag_d   = rsp_tag;
            data_d  = out_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) valid_q <= 1'b0;
        else         valid_q <= valid_d;
        dest_q <= dest_d;
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && accept)
            assert (legal) else $error("vx_mem_port_arb_rsp: response index %0d out of range", rsp_dest);
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_out
        assign in_rsp_valid_o[g] = valid_q && (dest_q == IDX_WI'(g));
        assign rsp_fire_o[g]     = in_rsp_valid_o[g] && in_rsp_ready_i[g];
    end

    assign in_rsp_data_o = data_q;
    assign in_rsp_tag_o  = tag_q;
endmodule

// File: rtl/vx_mem_port_arb.sv
// Round-robin arbiter sharing one memory port between NUM_INPUTS requesters.
//   state      | meaning
//   FIFO_EMPTY | no request buffered, out req_valid low
//   FIFO_ONE   | one request buffered, can accept and drain in the same cycle
//   FIFO_FULL  | both skid entries used, no grants issued
module vx_mem_port_arb
    import vx_mem_port_arb_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_SIZE   = 64,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    vx_mem_port_arb_if.slave  bus_in_if [NUM_INPUTS],
    vx_mem_port_arb_if.master bus_out_if
);
    localparam int IDX_W   = $clog2(NUM_INPUTS);
    localparam int IDX_WI  = idx_bits(NUM_INPUTS);
    localparam int DATA_W  = DATA_SIZE * 8;
    localparam int PEND_W  = $clog2(MAX_PENDING + 1);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_W + DATA_SIZE + TAG_WIDTH + IDX_WI;

    logic [NUM_INPUTS-1:0] eligible, grant, rsp_ready_in, rsp_valid_in, rsp_fire;
    logic [ENTRY_W-1:0]    in_entry [NUM_INPUTS];
    logic [DATA_W-1:0]     rsp_data_b;
    logic [TAG_WIDTH-1:0]  rsp_tag_b;

    logic [IDX_WI-1:0]     rr_ptr_q, rr_ptr_d, grant_idx, cand;
    logic                  grant_vld;

    fifo_state_e           fifo_state_q, fifo_state_d;
    logic [ENTRY_W-1:0]    fifo_mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q, push, pop;
    logic [ENTRY_W-1:0]    head;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic [IDX_WI-1:0]     head_idx;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              rd_acc;

        assign in_entry[g] = {bus_in_if[g].req_rw, bus_in_if[g].req_addr, bus_in_if[g].req_data,
                              bus_in_if[g].req_byteen, bus_in_if[g].req_tag, IDX_WI'(g)};
        assign eligible[g] = bus_in_if[g].req_valid
                           && (bus_in_if[g].req_rw || (32'(pend_q) < MAX_PENDING));
        assign grant[g]    = grant_vld && (grant_idx == IDX_WI'(g));
        assign rd_acc      = grant[g] && !bus_in_if[g].req_rw;

        assign bus_in_if[g].req_ready = grant[g];
        assign bus_in_if[g].rsp_valid = rsp_valid_in[g];
        assign bus_in_if[g].rsp_data  = rsp_data_b;
        assign bus_in_if[g].rsp_tag   = rsp_tag_b;
        assign rsp_ready_in[g]        = bus_in_if[g].rsp_ready;

        always_comb begin
            pend_d = pend_q;
            if (rd_acc && !rsp_fire[g])      pend_d = pend_q + 1'b1;
            else if (!rd_acc && rsp_fire[g]) pend_d = pend_q - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) pend_q <= '0;
            else       pend_q <= pend_d;
            if (!reset && rsp_fire[g])
                assert (pend_q != '0) else $error("vx_mem_port_arb: pending underflow on input %0d", g);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = IDX_WI'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_INPUTS));
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (reset || fifo_state_q == FIFO_FULL) grant_vld = 1'b0;
        rr_ptr_d = grant_vld ? IDX_WI'((32'(grant_idx) + 32'd1) % 32'(NUM_INPUTS)) : rr_ptr_q;
    end

    assign push = grant_vld;
    assign pop  = bus_out_if.req_valid && bus_out_if.req_ready;

    always_comb begin
        fifo_state_d = fifo_state_q;
        unique case (fifo_state_q)
            FIFO_EMPTY: if (push) fifo_state_d = FIFO_ONE;
            FIFO_ONE: begin
                if (push && !pop)      fifo_state_d = FIFO_FULL;
                else if (pop && !push) fifo_state_d = FIFO_EMPTY;
            end
            FIFO_FULL:  if (pop) fifo_state_d = FIFO_ONE;
            default:    fifo_state_d = FIFO_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_state_q <= FIFO_EMPTY;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            fifo_state_q <= fifo_state_d;
            rr_ptr_q     <= rr_ptr_d;
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= in_entry[grant_idx];
    end

    assign head = fifo_mem_q[rd_ptr_q];
    assign {bus_out_if.req_rw, bus_out_if.req_addr, bus_out_if.req_data,
            bus_out_if.req_byteen, head_tag, head_idx} = head;
    assign bus_out_if.req_valid = (fifo_state_q != FIFO_EMPTY);

    // Source index rides in the tag LSBs so responses can be routed back.
    if (IDX_W > 0) begin : g_tag_idx
        assign bus_out_if.req_tag = {head_tag, head_idx};
    end else begin : g_tag_pass
        assign bus_out_if.req_tag = head_tag;
    end

    vx_mem_port_arb_rsp #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_W     (DATA_W),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_rsp (
        .clk_i           (clk),
        .reset_i         (reset),
        .out_rsp_valid_i (bus_out_if.rsp_valid),
        .out_rsp_data_i  (bus_out_if.rsp_data),
        .out_rsp_tag_i   (bus_out_if.rsp_tag),
        .out_rsp_ready_o (bus_out_if.rsp_ready),
        .in_rsp_valid_o  (rsp_valid_in),
        .in_rsp_data_o   (rsp_data_b),
        .in_rsp_tag_o    (rsp_tag_b),
        .in_rsp_ready_i  (rsp_ready_in),
        .rsp_fire_o      (rsp_fire)
    );
endmodule

// File: tb/tb_vx_mem_port_arb.sv
// Directed self-checking bench for vx_mem_port_arb with two requesters.
module tb_vx_mem_port_arb;
    localparam int NI  = 2;
    localparam int AW  = 26;
    localparam int DS  = 4;
    localparam int DW  = DS * 8;
    localparam int TW  = 8;
    localparam int OTW = TW + 1;
    localparam int MP  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vx_mem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW))  in_if [NI] ();
    vx_mem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(OTW)) out_if ();

    logic [NI-1:0] req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
    logic [AW-1:0] req_addr [NI];
    logic [DW-1:0] req_data [NI];
    logic [TW-1:0] req_tag  [NI];
    logic [TW-1:0] rsp_tag  [NI];
    logic [DW-1:0] rsp_data [NI];

    logic           out_req_ready, out_rsp_valid;
    logic [OTW-1:0] out_rsp_tag;
    logic [DW-1:0]  out_rsp_data;

    for (genvar g = 0; g < NI; g++) begin : g_drv
        assign in_if[g].req_valid  = req_valid[g];
        assign in_if[g].req_rw     = req_rw[g];
        assign in_if[g].req_addr   = req_addr[g];
        assign in_if[g].req_data   = req_data[g];
        assign in_if[g].req_byteen = '1;
        assign in_if[g].req_tag    = req_tag[g];
        assign in_if[g].rsp_ready  = rsp_ready[g];
        assign req_ready[g]        = in_if[g].req_ready;
        assign rsp_valid[g]        = in_if[g].rsp_valid;
        assign rsp_tag[g]          = in_if[g].rsp_tag;
        assign rsp_data[g]         = in_if[g].rsp_data;
    end

    assign out_if.req_ready = out_req_ready;
    assign out_if.rsp_valid = out_rsp_valid;
    assign out_if.rsp_tag   = out_rsp_tag;
    assign out_if.rsp_data  = out_rsp_data;

    vx_mem_port_arb #(
        .NUM_INPUTS(NI), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_in_if  (in_if),
        .bus_out_if (out_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_rw    = '0;
        rsp_ready = '1;
        for (int i = 0; i < NI; i++) begin
            req_addr[i] = AW'(32'h100 * (i + 1));
            req_data[i] = DW'(32'hA000_0000 + i);
            req_tag[i]  = '0;
        end
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b0;
        out_rsp_tag   = '0;
        out_rsp_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        req_valid = '1;
        step();
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        checks++;
        if (out_if.req_valid !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_valids: out_req_valid %b rsp_valid %b want 0/00", out_if.req_valid, rsp_valid);
        end
        checks++;
        if (out_if.rsp_ready !== 1'b1) begin
            errors++; $display("FAIL reset_rsp_ready: got %b want 1", out_if.rsp_ready);
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [TW-1:0]  t;
        logic [OTW-1:0] exp_tag;
        logic [NI-1:0]  exp_g;
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_tag[0] = TW'(8'h10 + k);
            req_tag[1] = TW'(8'h20 + k);
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g);
            end
            step();
            t = (k % 2 == 0) ? TW'(8'h10 + k) : TW'(8'h20 + k);
            exp_tag = {t, 1'(k % 2)};
            checks++;
            if (out_if.req_valid !== 1'b1 || out_if.req_tag !== exp_tag) begin
                errors++; $display("FAIL rr_out_tag[%0d]: valid %b tag %h want 1 %h", k, out_if.req_valid, out_if.req_tag, exp_tag);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_pending_limit();
        do_reset();
        req_valid[0] = 1'b1;
        req_tag[0]   = 8'h33;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready[0] !== 1'b1) begin
                errors++; $display("FAIL pend_accept[%0d]: got %b want 1", k, req_ready[0]);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (req_ready[0] !== 1'b0) begin
                errors++; $display("FAIL pend_hold[%0d]: got %b want 0", k, req_ready[0]);
            end
            step();
        end
        out_rsp_valid = 1'b1;
        out_rsp_tag   = 9'h066;
        out_rsp_data  = 32'h1234_5678;
        #1;
        checks++;
        if (out_if.rsp_ready !== 1'b1 || req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL pend_rsp_in: rsp_ready %b req_ready %b want 1/0", out_if.rsp_ready, req_ready[0]);
        end
        step();
        out_rsp_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_tag[0] !== 8'h33 || rsp_data[0] !== 32'h1234_5678) begin
            errors++; $display("FAIL pend_rsp_out: valid %b tag %h data %h want 01 33 12345678", rsp_valid, rsp_tag[0], rsp_data[0]);
        end
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL pend_still_full: got %b want 0", req_ready[0]);
        end
        step();
        #1;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL pend_release: req_ready %b rsp_valid %b want 1/00", req_ready[0], rsp_valid);
        end
        step();
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL pend_refill: got %b want 0", req_ready[0]);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_write_bypass();
        do_reset();
        req_valid[1] = 1'b1;
        req_tag[1]   = 8'h44;
        for (int k = 0; k < 4; k++) step();
        req_rw[1]   = 1'b1;
        req_addr[1] = 26'h0ABCDE;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL wr_accept: got %b want 1", req_ready[1]);
        end
        step();
        #1;
        checks++;
        if (out_if.req_valid !== 1'b1 || out_if.req_rw !== 1'b1 || out_if.req_addr !== 26'h0ABCDE || out_if.req_tag !== 9'h089) begin
            errors++; $display("FAIL wr_out: valid %b rw %b addr %h tag %h want 1 1 0abcde 089",
                               out_if.req_valid, out_if.req_rw, out_if.req_addr, out_if.req_tag);
        end
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL wr_accept2: got %b want 1", req_ready[1]);
        end
        step();
        req_rw[1] = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL wr_pending_kept: req_ready %b rsp_valid %b want 0/00", req_ready[1], rsp_valid);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        int acc;
        do_reset();
        out_req_ready = 1'b0;
        req_valid     = 2'b11;
        req_tag[0]    = 8'h40;
        req_tag[1]    = 8'h50;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            acc += int'(req_ready[0]) + int'(req_ready[1]);
            if (c >= 1) begin
                checks++;
                if (out_if.req_valid !== 1'b1 || out_if.req_tag !== 9'h080 || out_if.req_addr !== 26'h100) begin
                    errors++; $display("FAIL stall_hold[%0d]: valid %b tag %h addr %h want 1 080 100",
                                       c, out_if.req_valid, out_if.req_tag, out_if.req_addr);
                end
            end
            step();
        end
        checks++;
        if (acc !== 2) begin
            errors++; $display("FAIL stall_accept_count: got %0d want 2", acc);
        end
        req_valid     = '0;
        out_req_ready = 1'b1;
        #1;
        checks++;
        if (out_if.req_valid !== 1'b1 || out_if.req_tag !== 9'h080) begin
            errors++; $display("FAIL drain_first: valid %b tag %h want 1 080", out_if.req_valid, out_if.req_tag);
        end
        step();
        checks++;
        if (out_if.req_valid !== 1'b1 || out_if.req_tag !== 9'h0A1 || out_if.req_addr !== 26'h200) begin
            errors++; $display("FAIL drain_second: valid %b tag %h addr %h want 1 0a1 200", out_if.req_valid, out_if.req_tag, out_if.req_addr);
        end
        step();
        checks++;
        if (out_if.req_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got %b want 0", out_if.req_valid);
        end
    endtask

    task automatic test_rsp_stall();
        do_reset();
        req_valid[1] = 1'b1;
        step();
        step();
        req_valid     = '0;
        rsp_ready[1]  = 1'b0;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = 9'h015;
        out_rsp_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (out_if.rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_accept_empty: got %b want 1", out_if.rsp_ready);
        end
        step();
        out_rsp_tag  = 9'h017;
        out_rsp_data = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 2'b10 || rsp_tag[1] !== 8'h0A || rsp_data[1] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL rsp_stall_hold[%0d]: valid %b tag %h data %h want 10 0a deadbeef",
                                   c, rsp_valid, rsp_tag[1], rsp_data[1]);
            end
            checks++;
            if (out_if.rsp_ready !== 1'b0) begin
                errors++; $display("FAIL rsp_stall_ready[%0d]: got %b want 0", c, out_if.rsp_ready);
            end
            step();
        end
        rsp_ready[1] = 1'b1;
        #1;
        checks++;
        if (out_if.rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_release_ready: got %b want 1", out_if.rsp_ready);
        end
        step();
        out_rsp_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_tag[1] !== 8'h0B || rsp_data[1] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rsp_back_to_back: valid %b tag %h data %h want 10 0b cafef00d", rsp_valid, rsp_tag[1], rsp_data[1]);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rsp_empty: got %b want 00", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid[0] = 1'b1;
        step();
        step();
        out_req_ready = 1'b0;
        step();
        #1;
        checks++;
        if (req_ready[0] !== 1'b0 || out_if.req_valid !== 1'b1) begin
            errors++; $display("FAIL mid_full: req_ready %b out_valid %b want 0/1", req_ready[0], out_if.req_valid);
        end
        reset     = 1'b1;
        req_valid = 2'b11;
        step();
        #1;
        checks++;
        if (req_ready !== 2'b00 || out_if.req_valid !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL mid_reset_outputs: req_ready %b out_valid %b rsp_valid %b want 00 0 00",
                               req_ready, out_if.req_valid, rsp_valid);
        end
        reset         = 1'b0;
        out_req_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL mid_first_grant: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready[0] !== 1'b1) begin
                errors++; $display("FAIL mid_pending_cleared[%0d]: got %b want 1", k, req_ready[0]);
            end
            step();
        end
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL mid_pending_limit: got %b want 0", req_ready[0]);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_pending_limit();
        test_write_bypass();
        test_stall();
        test_rsp_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
